// File: rtl/req_stage_queue.sv
// Four per-client request FIFOs feeding a round-robin arbiter: req/full come from
// registered occupancy, and a legal one-hot grant pops the head into a registered output.
module req_stage_queue #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      push,
  input  logic [4*DW-1:0] push_data,
  output logic [3:0]      full,
  output logic [3:0]      req,
  input  logic [3:0]      gnt,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic [1:0]      out_id,
  output logic            err_ovf,
  output logic            err_gnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem   [4][DEPTH];
  logic [AW-1:0] wptr  [4];
  logic [AW-1:0] rptr  [4];
  logic [CW-1:0] count [4];

  logic [1:0]    gnt_idx;
  logic          gnt_onehot;
  logic          gnt_legal;
  logic [3:0]    pop;
  logic [3:0]    wr_en;
  logic          ovf_hit;
  logic [DW-1:0] head;

  // Grant decode and per-client push/pop enables, all from pre-edge counts
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < 4; i++)
      if (gnt[i]) gnt_idx = 2'(i);
    gnt_onehot = (gnt != 4'd0) && ((gnt & (gnt - 4'd1)) == 4'd0);
    gnt_legal  = gnt_onehot && (count[gnt_idx] != '0);
    req   = '0;
    full  = '0;
    pop   = '0;
    wr_en = '0;
    for (int i = 0; i < 4; i++) begin
      req[i]   = (count[i] != '0);
      full[i]  = (count[i] == CW'(DEPTH));
      pop[i]   = gnt_legal && gnt[i];
      // A full FIFO still takes a word when its head leaves in the same cycle
      wr_en[i] = push[i] && (!full[i] || pop[i]);
    end
    ovf_hit = |(push & full & ~pop);
    head    = mem[gnt_idx][rptr[gnt_idx]];
  end

  // Occupancy state and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        wptr[i]  <= '0;
        rptr[i]  <= '0;
        count[i] <= '0;
      end
      err_ovf <= 1'b0;
      err_gnt <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (wr_en[i]) wptr[i] <= wptr[i] + AW'(1);
        if (pop[i])   rptr[i] <= rptr[i] + AW'(1);
        count[i] <= count[i] + CW'(wr_en[i]) - CW'(pop[i]);
      end
      if (ovf_hit)                   err_ovf <= 1'b1;
      if (gnt != 4'd0 && !gnt_legal) err_gnt <= 1'b1;
    end
  end

  // Storage is never reset; pointers alone define what is valid
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (wr_en[i]) mem[i][wptr[i]] <= push_data[i*DW +: DW];
  end

  // Output register: one-cycle strobe, data/id hold between pops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
    end else begin
      out_valid <= gnt_legal;
      if (gnt_legal) begin
        out_data <= head;
        out_id   <= gnt_idx;
      end
    end
  end

endmodule
